// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, state encoding,
// ALUOp codes (matching the ALU control decoder), mux selects and the
// packed control word driven to the datapath.
package control_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned SEL_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SHIFTI = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_ADDI   = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_LW     = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_SW     = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_BEQ    = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_BNE    = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_SLTI   = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_J      = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_R_WB     = 4'd10,
    S_I_WB     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  // ALUOp codes; 4..6 are reserved by the ALU control decoder.
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SHIFT = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'd7;

  localparam logic [SEL_W-1:0] SRCB_B     = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_TWO   = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_SHIMM = 2'd3;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               branch_ne;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   pc_source;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle.
//   master: the control FSM (takes Opcode/Zero/MemReady, drives controls, State)
//   slave : the datapath side (drives Opcode/Zero/MemReady, takes controls)
interface multicycle_control_if;
  import control_pkg::*;

  logic [OPCODE_W-1:0] Opcode;
  logic                Zero;
  logic                MemReady;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                BranchNe;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic                ALUSrcA;
  logic [SEL_W-1:0]    ALUSrcB;
  logic [SEL_W-1:0]    PCSource;
  logic [ALUOP_W-1:0]  ALUOp;
  logic [STATE_W-1:0]  State;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, State
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, State
  );
endinterface

// File: rtl/control_word_decode.sv
// Combinational decode of (state, opcode, mem_ready) into the datapath
// control word. All fields are 0 while rst is high.
//   rst       : synchronous reset level, forces an all-zero word
//   state     : current FSM state
//   opcode    : IR[15:12]
//   mem_ready : memory handshake, only gates IRWrite/PCWrite in FETCH
//   ctrl      : control word
module control_word_decode
  import control_pkg::*;
(
  input  logic                rst,
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_TWO;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          // IR and PC advance only on the cycle the fetch completes
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_SHIMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = (opcode == OP_SHIFTI) ? SRCB_IMM : SRCB_B;
          ctrl.alu_op    = (opcode == OP_SHIFTI) ? ALUOP_SHIFT : ALUOP_RTYPE;
        end
        S_EXEC_I: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = (opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.branch_ne     = (opcode == OP_BNE);
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        S_R_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_I_WB: begin
          ctrl.reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath: sequences fetch, decode,
// execute, memory and writeback steps and stalls on MemReady.
//   CLK, Reset : clock, synchronous active-high reset
//   bus        : multicycle_control_if.master (Opcode/Zero/MemReady in,
//                datapath controls, ALUOp and debug State out)
// Build option HALT_ON_ILLEGAL_EN: illegal opcodes park the FSM in HALT until
// Reset; otherwise they retire as a 2-cycle NOP.
module multicycle_control
  import control_pkg::*;
(
  input  logic                 CLK,
  input  logic                 Reset,
  multicycle_control_if.master bus
);

`ifdef HALT_ON_ILLEGAL_EN
  localparam state_t ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  state_t state;
  ctrl_t  ctrl;

  // State register with transition logic
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (bus.MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (bus.Opcode)
            OP_RTYPE, OP_SHIFTI: state <= S_EXEC_R;
            OP_ADDI, OP_SLTI:    state <= S_EXEC_I;
            OP_LW, OP_SW:        state <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:      state <= S_BRANCH;
            OP_J:                state <= S_JUMP;
            default:             state <= ILLEGAL_NEXT;
          endcase
        end
        S_EXEC_R:   state <= S_R_WB;
        S_EXEC_I:   state <= S_I_WB;
        S_MEM_ADDR: state <= (bus.Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.MemReady) state <= S_MEM_WB;
        S_MEM_WR:   if (bus.MemReady) state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  control_word_decode u_decode (
    .rst       (Reset),
    .state     (state),
    .opcode    (bus.Opcode),
    .mem_ready (bus.MemReady),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.BranchNe    = ctrl.branch_ne;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUOp       = ctrl.alu_op;
  // Debug state also reads 0 while Reset is held
  assign bus.State       = Reset ? STATE_W'(0) : STATE_W'(state);

endmodule
